// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and product width.
package shift_add_multiplier_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    ADD_REQ  = 3'd2,
    ADD_WAIT = 3'd3,
    DONE     = 3'd4
  } state_e;

  function automatic int prod_width(input int a_width, input int b_width);
    return a_width + b_width;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand-side and product-side STB/ACK handshake of the shift-add multiplier.
interface shift_add_multiplier_if #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32
);
  import shift_add_multiplier_pkg::*;

  logic                                     I_STB;
  logic                                     I_ACK;
  logic [A_WIDTH-1:0]                       I_DAT_A;
  logic [B_WIDTH-1:0]                       I_DAT_B;
  logic                                     O_STB;
  logic [prod_width(A_WIDTH, B_WIDTH)-1:0]  O_DAT;
  logic                                     O_ACK;

  modport master (
    output I_STB, I_DAT_A, I_DAT_B, O_ACK,
    input  I_ACK, O_STB, O_DAT
  );

  modport slave (
    input  I_STB, I_DAT_A, I_DAT_B, O_ACK,
    output I_ACK, O_STB, O_DAT
  );

endinterface

// File: rtl/shift_add_multiplier_adder.sv
// Single-result STB/ACK adder: registers A+B (carry included) on accept, holds it until O_ACK.
module shift_add_multiplier_adder #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  localparam int SUM_W  = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               I_STB,
  output logic               I_ACK,
  input  logic [A_WIDTH-1:0] I_DAT_A,
  input  logic [B_WIDTH-1:0] I_DAT_B,
  output logic               O_STB,
  output logic [SUM_W-1:0]   O_DAT,
  input  logic               O_ACK
);

  logic             o_stb_q, o_stb_d;
  logic [SUM_W-1:0] o_dat_q, o_dat_d;

  // Only one result in flight: a new request waits until the previous sum is taken.
  assign I_ACK = I_STB & ~o_stb_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    o_stb_d = o_stb_q;
    o_dat_d = o_dat_q;
    if (O_ACK && o_stb_q) begin
      o_stb_d = 1'b0;
    end
    if (I_ACK) begin
      o_stb_d = 1'b1;
      o_dat_d = SUM_W'(I_DAT_A) + SUM_W'(I_DAT_B);
    end
  end

  // NOTE: async active-high reset here, so the parent's synchronous reset clears it immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_stb_q <= 1'b0;
      o_dat_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      o_stb_q <= o_stb_d;
      o_dat_q <= o_dat_d;
    end
  end

  assign O_STB = o_stb_q;
  assign O_DAT = o_dat_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned sequential multiplier: one multiplier bit per step, partial sums via the STB/ACK adder.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  shift_add_multiplier_if.slave bus
);

  localparam int PW    = prod_width(A_WIDTH, B_WIDTH);
  localparam int CNT_W = $clog2(B_WIDTH + 1);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] a_q, a_d;
  logic [A_WIDTH-1:0] hi_q, hi_d;
  logic [B_WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               o_stb_q, o_stb_d;
  logic [PW-1:0]      o_dat_q, o_dat_d;

  logic               i_ack;
  logic               add_rst;
  logic               add_i_stb;
  logic               add_i_ack;
  logic               add_o_stb;
  logic               add_o_ack;
  logic [A_WIDTH:0]   add_o_dat;
  logic [PW:0]        add_cat;

  assign add_rst = ~RST;
  assign add_cat = {add_o_dat, lo_q};

  shift_add_multiplier_adder #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (A_WIDTH)
  ) u_adder (
    .CLK     (CLK),
    .RST     (add_rst),
    .I_STB   (add_i_stb),
    .I_ACK   (add_i_ack),
    .I_DAT_A (hi_q),
    .I_DAT_B (a_q),
    .O_STB   (add_o_stb),
    .O_DAT   (add_o_dat),
    .O_ACK   (add_o_ack)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    o_stb_d   = o_stb_q;
    o_dat_d   = o_dat_q;
    i_ack     = 1'b0;
    add_i_stb = 1'b0;
    add_o_ack = 1'b0;

    unique case (state_q)
      IDLE: begin
        i_ack = bus.I_STB & RST;
        if (i_ack) begin
          a_d     = bus.I_DAT_A;
          hi_d    = '0;
          lo_d    = bus.I_DAT_B;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (cnt_q == CNT_W'(B_WIDTH)) begin
          o_dat_d = {hi_q, lo_q};
          o_stb_d = 1'b1;
          state_d = DONE;
        end else if (!lo_q[0]) begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[B_WIDTH-1:1]};
          cnt_d        = cnt_q + CNT_W'(1);
        end else begin
          state_d = ADD_REQ;
        end
      end
      ADD_REQ: begin
        add_i_stb = 1'b1;
        if (add_i_ack) begin
          state_d = ADD_WAIT;
        end
      end
      ADD_WAIT: begin
        // The adder carry lands in the top bit of hi as the pair shifts right.
        if (add_o_stb) begin
          add_o_ack    = 1'b1;
          {hi_d, lo_d} = add_cat[PW:1];
          cnt_d        = cnt_q + CNT_W'(1);
          state_d      = SCAN;
        end
      end
      DONE: begin
        if (bus.O_ACK) begin
          o_stb_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      o_stb_q <= 1'b0;
      o_dat_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      o_stb_q <= o_stb_d;
      o_dat_q <= o_dat_d;
    end
  end

  assign bus.I_ACK = i_ack;
  assign bus.O_STB = o_stb_q;
  assign bus.O_DAT = o_dat_q;

endmodule
